// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared types and constants for the core_v2 processor:
//               instruction-type and FSM-state enums, instruction field bit
//               positions, the PC register index and the RAM select value.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

   typedef enum logic [2:0] {
      T_NOP          = 3'd0,
      T_CALC_CONST_A = 3'd1,
      T_CALC_CONST_B = 3'd2,
      T_CALC         = 3'd3,
      T_MEM_ACT      = 3'd4,
      T_HLT          = 3'd5,
      T_BRANCH       = 3'd6,
      T_ILLEGAL      = 3'd7
   } instr_type_e;

   typedef enum logic [2:0] {
      S_FETCH   = 3'd0,
      S_EXECUTE = 3'd1,
      S_MEM     = 3'd2,
      S_PC_INC  = 3'd3,
      S_HALT    = 3'd4
   } state_e;

   // Instruction field positions. IMM15 overlaps REG_C, IMM20 overlaps REG_B/REG_C.
   localparam int c_type_lsb  = 0;
   localparam int c_type_msb  = 2;
   localparam int c_op_lsb    = 3;
   localparam int c_op_msb    = 6;
   localparam int c_rega_lsb  = 7;
   localparam int c_rega_msb  = 11;
   localparam int c_regb_lsb  = 12;
   localparam int c_regb_msb  = 16;
   localparam int c_regc_lsb  = 17;
   localparam int c_regc_msb  = 21;
   localparam int c_imm15_lsb = 17;
   localparam int c_imm20_lsb = 12;
   localparam int c_imm_msb   = 31;

   localparam logic [4:0] c_pc_idx  = 5'd31;
   localparam int         c_sel_ram = 0;

endpackage
`default_nettype wire

// File: rtl/core_if.sv
`default_nettype none
// ============================================================================
// Module      : core_if
// Description : Shared memory/peripheral bus with a req/ack handshake.
//               master: req, addr, sel, op, wdata out; ack, rdata in.
//               slave : mirror of master.
//               op[0]=1 marks a write; otherwise rdata is returned on ack.
// Revision    : 1.0 - initial release
// ============================================================================
interface core_if #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 13,
   parameter int SEL_W  = 2
);
   logic              req;
   logic [ADDR_W-1:0] addr;
   logic [SEL_W-1:0]  sel;
   logic [1:0]        op;
   logic [XLEN-1:0]   wdata;
   logic              ack;
   logic [XLEN-1:0]   rdata;

   modport master (output req, addr, sel, op, wdata, input ack, rdata);
   modport slave  (input req, addr, sel, op, wdata, output ack, rdata);
endinterface
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module      : alu
// Description : Combinational ALU shared with the first-generation core.
//               op     : 4-bit operation select
//               a, b   : operands
//               pc     : current program counter (for PC-relative op)
//               result : operation result
//               Ops: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL,
//                    7 SLTU, 8 PASS A, 9 PASS B, 10 PC+B, others 0.
// Revision    : 1.0 - initial release
// ============================================================================
module alu #(
   parameter int bit_width = 32
)(
   input  wire logic [3:0]           op,
   input  wire logic [bit_width-1:0] a,
   input  wire logic [bit_width-1:0] b,
   input  wire logic [bit_width-1:0] pc,
   output logic      [bit_width-1:0] result
);
   always_comb begin
      result = '0;
      case (op)
         4'd0:    result = a + b;
         4'd1:    result = a - b;
         4'd2:    result = a & b;
         4'd3:    result = a | b;
         4'd4:    result = a ^ b;
         4'd5:    result = a << b[4:0];
         4'd6:    result = a >> b[4:0];
         4'd7:    result = {{(bit_width-1){1'b0}}, (a < b)};
         4'd8:    result = a;
         4'd9:    result = b;
         4'd10:   result = pc + b;
         default: result = '0;
      endcase
   end
endmodule
`default_nettype wire

// File: rtl/core_regfile.sv
`default_nettype none
// ============================================================================
// Module      : core_regfile
// Description : 32 x XLEN register file, register 31 is the PC.
//               clk, rst          : clock, synchronous active-high reset
//               we, waddr, wdata  : single write port
//               ra_a/ra_b/ra_c    : combinational read addresses
//               rd_a/rd_b/rd_c    : combinational read data
//               pc                : dedicated PC read
//               Only the PC is reset (to RESET_PC).
// Revision    : 1.0 - initial release
// ============================================================================
module core_regfile
   import core_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
)(
   input  wire logic            clk,
   input  wire logic            rst,
   input  wire logic            we,
   input  wire logic [4:0]      waddr,
   input  wire logic [XLEN-1:0] wdata,
   input  wire logic [4:0]      ra_a,
   input  wire logic [4:0]      ra_b,
   input  wire logic [4:0]      ra_c,
   output logic      [XLEN-1:0] rd_a,
   output logic      [XLEN-1:0] rd_b,
   output logic      [XLEN-1:0] rd_c,
   output logic      [XLEN-1:0] pc
);
   // Entry 31 of the array is never used; the PC lives in its own register.
   logic [XLEN-1:0] r_gpr [0:31];
   logic [XLEN-1:0] r_pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc <= RESET_PC;
      end else if (we && waddr == c_pc_idx) begin
         r_pc <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && we && waddr != c_pc_idx) begin
         r_gpr[waddr] <= wdata;
      end
   end

   assign rd_a = (ra_a == c_pc_idx) ? r_pc : r_gpr[ra_a];
   assign rd_b = (ra_b == c_pc_idx) ? r_pc : r_gpr[ra_b];
   assign rd_c = (ra_c == c_pc_idx) ? r_pc : r_gpr[ra_c];
   assign pc   = r_pc;
endmodule
`default_nettype wire

// File: rtl/core_v2.sv
`default_nettype none
// ============================================================================
// Module      : core_v2
// Description : Multi-cycle core: FETCH -> EXECUTE -> (MEM) -> PC_INC around
//               a 32-entry register file, driving one shared req/ack bus.
//               clk, rst : clock, synchronous active-high reset
//               bus      : core_if master (instruction fetch and MEM_ACT)
//               halted   : core is in HALT
//               illegal  : sticky, halted on an undefined instruction type
//               pc       : current RF[31]
// Revision    : 1.0 - initial release
// ============================================================================
module core_v2
   import core_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter int              ADDR_W   = 13,
   parameter int              SEL_W    = 2,
   parameter logic [XLEN-1:0] RESET_PC = '0
)(
   input  wire logic  clk,
   input  wire logic  rst,
   core_if.master     bus,
   output logic       halted,
   output logic       illegal,
   output logic [XLEN-1:0] pc
);
   state_e          r_state, w_next;
   logic [31:0]     r_instr;
   logic            r_halted, r_illegal;

   logic            w_instr_load, w_set_halt, w_set_illegal;
   logic            w_we;
   logic [4:0]      w_waddr;
   logic [XLEN-1:0] w_wdata;
   logic [XLEN-1:0] w_rf_a, w_rf_b, w_rf_c, w_pc, w_pc_inc;
   logic [XLEN-1:0] w_alu_a, w_alu_b, w_alu_y;

   instr_type_e     w_type;
   logic [3:0]      w_op;
   logic [4:0]      w_ra, w_rb, w_rc;
   logic [XLEN-1:0] w_imm15, w_imm20;

   assign w_type  = instr_type_e'(r_instr[c_type_msb:c_type_lsb]);
   assign w_op    = r_instr[c_op_msb:c_op_lsb];
   assign w_ra    = r_instr[c_rega_msb:c_rega_lsb];
   assign w_rb    = r_instr[c_regb_msb:c_regb_lsb];
   assign w_rc    = r_instr[c_regc_msb:c_regc_lsb];
   assign w_imm15 = XLEN'(r_instr[c_imm_msb:c_imm15_lsb]);
   assign w_imm20 = XLEN'(r_instr[c_imm_msb:c_imm20_lsb]);
   assign w_pc_inc = w_pc + XLEN'(1);

   core_regfile #(.XLEN(XLEN), .RESET_PC(RESET_PC)) u_regfile (
      .clk   (clk),
      .rst   (rst),
      .we    (w_we),
      .waddr (w_waddr),
      .wdata (w_wdata),
      .ra_a  (w_ra),
      .ra_b  (w_rb),
      .ra_c  (w_rc),
      .rd_a  (w_rf_a),
      .rd_b  (w_rf_b),
      .rd_c  (w_rf_c),
      .pc    (w_pc)
   );

   assign w_alu_a = (w_type == T_CALC_CONST_A) ? w_imm20 : w_rf_b;
   assign w_alu_b = (w_type == T_CALC_CONST_B) ? w_imm15 : w_rf_c;

   alu #(.bit_width(XLEN)) u_alu (
      .op     (w_op),
      .a      (w_alu_a),
      .b      (w_alu_b),
      .pc     (w_pc),
      .result (w_alu_y)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_FETCH;
         r_instr   <= '0;
         r_halted  <= 1'b0;
         r_illegal <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_instr_load)  r_instr   <= bus.rdata[31:0];
         if (w_set_halt)    r_halted  <= 1'b1;
         if (w_set_illegal) r_illegal <= 1'b1;
      end
   end

   always_comb begin
      w_next        = r_state;
      w_instr_load  = 1'b0;
      w_set_halt    = 1'b0;
      w_set_illegal = 1'b0;
      w_we          = 1'b0;
      w_waddr       = w_ra;
      w_wdata       = w_alu_y;
      bus.req       = 1'b0;
      bus.addr      = w_pc[ADDR_W-1:0];
      bus.sel       = SEL_W'(c_sel_ram);
      bus.op        = 2'b00;
      bus.wdata     = w_rf_a;

      case (r_state)
         S_FETCH: begin
            bus.req = 1'b1;
            if (bus.ack) begin
               w_instr_load = 1'b1;
               w_next       = S_EXECUTE;
            end
         end
         S_EXECUTE: begin
            case (w_type)
               T_NOP: w_next = S_PC_INC;
               T_CALC_CONST_A, T_CALC_CONST_B, T_CALC: begin
                  w_we   = 1'b1;
                  // A write to the PC is a jump: skip the increment.
                  w_next = (w_ra == c_pc_idx) ? S_FETCH : S_PC_INC;
               end
               T_MEM_ACT: w_next = S_MEM;
               T_HLT: begin
                  w_set_halt = 1'b1;
                  w_next     = S_HALT;
               end
               T_BRANCH: begin
                  w_we    = 1'b1;
                  w_waddr = c_pc_idx;
                  w_wdata = (w_rf_a != '0) ? w_rf_b : w_pc_inc;
                  w_next  = S_FETCH;
               end
               default: begin
                  w_set_halt    = 1'b1;
                  w_set_illegal = 1'b1;
                  w_next        = S_HALT;
               end
            endcase
         end
         S_MEM: begin
            bus.req  = 1'b1;
            bus.addr = w_rf_b[ADDR_W-1:0];
            bus.sel  = SEL_W'(w_op[3:2]);
            bus.op   = w_op[1:0];
            if (bus.ack) begin
               if (!w_op[0]) begin
                  w_we    = 1'b1;
                  w_wdata = bus.rdata;
                  w_next  = (w_ra == c_pc_idx) ? S_FETCH : S_PC_INC;
               end else begin
                  w_next = S_PC_INC;
               end
            end
         end
         S_PC_INC: begin
            w_we    = 1'b1;
            w_waddr = c_pc_idx;
            w_wdata = w_pc_inc;
            w_next  = S_FETCH;
         end
         S_HALT:  w_next = S_HALT;
         default: w_next = S_FETCH;
      endcase

      // Reset abandons any transaction in flight and blocks writeback.
      if (rst) begin
         bus.req = 1'b0;
         w_we    = 1'b0;
      end
   end

   assign halted  = r_halted;
   assign illegal = r_illegal;
   assign pc      = w_pc;
endmodule
`default_nettype wire

// File: tb/tb_core_v2.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_v2
// Description : Self-checking bench for core_v2: bus responder with wait
//               states, instruction-level reference model, directed and
//               randomized programs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_v2;
   localparam int          XLEN   = 32;
   localparam int          ADDR_W = 13;
   localparam int          SEL_W  = 2;
   localparam logic [31:0] RST_PC = 32'h10;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        halted, illegal;
   logic [31:0] pc;

   core_if #(.XLEN(XLEN), .ADDR_W(ADDR_W), .SEL_W(SEL_W)) bus ();

   core_v2 #(.XLEN(XLEN), .ADDR_W(ADDR_W), .SEL_W(SEL_W), .RESET_PC(RST_PC)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .halted  (halted),
      .illegal (illegal),
      .pc      (pc)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // ---------------- environment memory (per select) ----------------
   logic [31:0] mem [0:3][0:8191];

   // ---------------- reference model (instruction level) ----------------
   logic [31:0] m_reg [0:30];
   logic [31:0] m_pc;
   bit          m_mem_phase, m_halt, m_ill;
   int          m_halt_age;
   logic [31:0] m_instr;

   function automatic logic [31:0] rd(input int i);
      return (i == 31) ? m_pc : m_reg[i];
   endfunction

   function automatic logic [31:0] alu_ref(input int op, input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] p);
      case (op)
         0: return a + b;
         1: return a - b;
         2: return a & b;
         3: return a | b;
         4: return a ^ b;
         5: return a << b[4:0];
         6: return a >> b[4:0];
         7: return (a < b) ? 32'd1 : 32'd0;
         8: return a;
         9: return b;
         10: return p + b;
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_step(input logic [12:0] addr, input logic [1:0] sel, input logic [1:0] op,
                             input logic [31:0] wdata, input logic [31:0] rdata);
      int t, o, ra, rb, rc;
      logic [31:0] opa, opb, r;
      if (!m_mem_phase) begin
         check("fetch_addr", addr, m_pc[12:0]);
         check("fetch_selop", {sel, op}, 4'h0);
         check("fetch_pc", pc, m_pc);
         m_instr = rdata;
      end
      t  = int'(m_instr[2:0]);
      o  = int'(m_instr[6:3]);
      ra = int'(m_instr[11:7]);
      rb = int'(m_instr[16:12]);
      rc = int'(m_instr[21:17]);
      if (m_mem_phase) begin
         check("mem_addr", addr, rd(rb) & 32'h1FFF);
         check("mem_sel", sel, o[3:2]);
         check("mem_op", op, o[1:0]);
         check("mem_wdata", wdata, rd(ra));
         if (o[0] == 1'b0) begin
            if (ra == 31) m_pc = rdata;
            else begin m_reg[ra] = rdata; m_pc = m_pc + 1; end
         end else m_pc = m_pc + 1;
         m_mem_phase = 0;
      end else begin
         case (t)
            0: m_pc = m_pc + 1;
            1, 2, 3: begin
               opa = (t == 1) ? {12'd0, m_instr[31:12]} : rd(rb);
               opb = (t == 2) ? {17'd0, m_instr[31:17]} : rd(rc);
               r   = alu_ref(o, opa, opb, m_pc);
               if (ra == 31) m_pc = r;
               else begin m_reg[ra] = r; m_pc = m_pc + 1; end
            end
            4: m_mem_phase = 1;
            5: begin m_halt = 1; m_halt_age = 0; end
            6: m_pc = (rd(ra) != 0) ? rd(rb) : m_pc + 1;
            default: begin m_halt = 1; m_ill = 1; m_halt_age = 0; end
         endcase
      end
   endtask

   // ---------------- responder + per-cycle compare ----------------
   int          cyc = 0;
   int          hs_n, cnt, wait_cur, halt_cyc;
   int          special_idx = -1;
   int          special_wait = 0;
   bit          rand_waits = 0;
   bit          prev_req, prev_ack, prev_halted;
   logic [48:0] prev_bus;
   int          log_cyc[$];
   logic [31:0] log_addr[$];
   logic [31:0] log_wdata[$];

   always @(negedge clk) begin
      logic [31:0] rdv;
      cyc++;
      if (rst) begin
         check("req_in_reset", bus.req, 1'b0);
         bus.ack = 1'b0;
         cnt = 0; hs_n = 0; prev_req = 0; prev_ack = 0; prev_halted = 0; halt_cyc = -1;
         m_pc = RST_PC; m_mem_phase = 0; m_halt = 0; m_ill = 0; m_halt_age = 0;
         log_cyc.delete(); log_addr.delete(); log_wdata.delete();
      end else begin
         if (m_halt) m_halt_age++;
         if (!m_halt) check("not_halted", {halted, illegal}, 2'b00);
         else if (m_halt_age >= 2) check("halt_state", {halted, illegal, bus.req}, {1'b1, m_ill, 1'b0});
         if (halted && !prev_halted) halt_cyc = cyc;
         prev_halted = halted;
         if (prev_ack) check("req_drop_after_ack", bus.req, 1'b0);
         else if (prev_req && bus.req)
            check("bus_stable", {bus.addr, bus.sel, bus.op, bus.wdata}, prev_bus);
         if (bus.req) begin
            if (cnt == 0)
               wait_cur = (hs_n == special_idx) ? special_wait :
                          (rand_waits ? int'($urandom_range(0, 3)) : 0);
            if (cnt >= wait_cur) begin
               if (bus.op[0]) begin
                  mem[bus.sel][bus.addr] = bus.wdata;
                  rdv = $urandom;
               end else rdv = mem[bus.sel][bus.addr];
               bus.rdata = rdv;
               bus.ack   = 1'b1;
               model_step(bus.addr, bus.sel, bus.op, bus.wdata, rdv);
               log_cyc.push_back(cyc);
               log_addr.push_back({19'd0, bus.addr});
               log_wdata.push_back(bus.wdata);
               hs_n++;
               cnt = 0;
            end else begin
               bus.ack = 1'b0;
               cnt++;
            end
         end else begin
            bus.ack = 1'b0;
            cnt = 0;
         end
         prev_req = bus.req;
         prev_ack = bus.ack;
         prev_bus = {bus.addr, bus.sel, bus.op, bus.wdata};
      end
   end

   // ---------------- helpers ----------------
   function automatic logic [31:0] enc_r(input int t, input int op, input int a, input int b, input int c);
      logic [31:0] w = '0;
      w[2:0] = t[2:0]; w[6:3] = op[3:0]; w[11:7] = a[4:0]; w[16:12] = b[4:0]; w[21:17] = c[4:0];
      return w;
   endfunction

   function automatic logic [31:0] enc_i15(input int t, input int op, input int a, input int b, input int imm);
      logic [31:0] w = '0;
      w[2:0] = t[2:0]; w[6:3] = op[3:0]; w[11:7] = a[4:0]; w[16:12] = b[4:0]; w[31:17] = imm[14:0];
      return w;
   endfunction

   function automatic logic [31:0] enc_i20(input int t, input int op, input int a, input int imm);
      logic [31:0] w = '0;
      w[2:0] = t[2:0]; w[6:3] = op[3:0]; w[11:7] = a[4:0]; w[31:12] = imm[19:0];
      return w;
   endfunction

   task automatic do_reset();
      @(posedge clk); #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_pc", pc, RST_PC);
      check("reset_flags", {halted, illegal}, 2'b00);
      rst = 1'b0;
      #1;
      check("first_req", {bus.req, bus.addr, bus.sel, bus.op}, {1'b1, 13'h10, 2'b00, 2'b00});
   endtask

   task automatic wait_halt(input int budget);
      int i;
      for (i = 0; i < budget && !halted; i++) @(posedge clk);
      #1 check("halt_reached", halted, 1'b1);
      repeat (4) @(posedge clk);
   endtask

   initial begin
      int addr, t, op, a, b, c, sel, mop;
      for (int s = 0; s < 4; s++)
         for (int i = 0; i < 8192; i++) mem[s][i] = 32'd0;

      // ---- directed program, zero-wait except one read with 3 waits ----
      mem[0][16'h10] = enc_i20(1, 8, 0, 0);            // r0 = 0
      mem[0][16'h11] = enc_i15(2, 0, 1, 0, 5);         // r1 = r0 + 5
      mem[0][16'h12] = enc_i15(2, 0, 2, 0, 32'h20);    // r2 = 0x20
      mem[0][16'h13] = enc_r(4, 4'b0001, 1, 2, 0);     // write RAM[r2] = r1
      mem[0][16'h14] = enc_r(4, 4'b0000, 3, 2, 0);     // r3 = RAM[r2]
      mem[0][16'h15] = enc_r(4, 4'b0101, 3, 0, 0);     // write sel1[r0] = r3
      mem[0][16'h16] = enc_r(6, 0, 0, 2, 0);           // branch on r0 (not taken)
      mem[0][16'h17] = enc_i15(2, 0, 4, 0, 1);         // r4 = 1
      mem[0][16'h18] = enc_i15(2, 0, 5, 0, 32'h40);    // r5 = 0x40
      mem[0][16'h19] = enc_r(6, 0, 4, 5, 0);           // branch on r4 -> 0x40
      mem[0][16'h40] = enc_i15(2, 0, 7, 0, 7);         // r7 = 7
      mem[0][16'h41] = enc_r(3, 0, 31, 7, 0);          // pc = r7 + r0
      mem[0][16'h07] = enc_r(5, 0, 0, 0, 0);           // HLT
      special_idx = 6; special_wait = 3;
      do_reset();
      wait_halt(500);
      check("hs_count", log_cyc.size(), 16);
      if (log_cyc.size() == 16) begin
         check("alu_next_addr", log_addr[2], 32'h12);
         check("alu_latency", log_cyc[2] - log_cyc[1], 3);
         check("mem_wr_addr", log_addr[4], 32'h20);
         check("mem_wr_data", log_wdata[4], 32'h5);
         check("mem_latency", log_cyc[5] - log_cyc[3], 4);
         check("mem_wait3_latency", log_cyc[7] - log_cyc[5], 7);
         check("read_writeback", log_wdata[8], 32'h5);
         check("br_not_taken", log_addr[10], 32'h17);
         check("br_nt_latency", log_cyc[10] - log_cyc[9], 2);
         check("br_taken", log_addr[13], 32'h40);
         check("br_t_latency", log_cyc[13] - log_cyc[12], 2);
         check("pc_write_addr", log_addr[15], 32'h7);
         check("pc_write_latency", log_cyc[15] - log_cyc[14], 2);
         check("hlt_latency", halt_cyc - log_cyc[15], 2);
      end
      check("hlt_flags", {halted, illegal}, 2'b10);

      // ---- reset during a MEM wait, then illegal instruction ----
      mem[0][16'h10] = enc_r(4, 4'b1000, 6, 0, 0);     // read sel2, long wait
      special_idx = 1; special_wait = 50;
      do_reset();
      for (int i = 0; i < 20 && hs_n < 1; i++) @(posedge clk);
      repeat (3) @(posedge clk);
      #1 check("mem_pending", bus.req, 1'b1);
      rst = 1'b1;
      #1 check("abort_req_low", bus.req, 1'b0);
      special_idx = -1;
      mem[0][16'h10] = enc_r(7, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1 check("abort_pc", pc, RST_PC);
      rst = 1'b0;
      wait_halt(100);
      check("restart_fetch", log_addr.size() > 0 ? log_addr[0] : 32'hFFFF_FFFF, 32'h10);
      check("illegal_hs_count", log_addr.size(), 1);
      check("illegal_flags", {halted, illegal}, 2'b11);

      // ---- randomized programs with random wait states ----
      rand_waits = 1;
      for (int p = 0; p < 6; p++) begin
         addr = 16'h10;
         for (int r = 0; r < 31; r++) begin
            mem[0][addr] = enc_i20(1, 8, r, int'($urandom_range(0, 20'hFFFFF)));
            addr++;
         end
         for (int k = 0; k < 40; k++) begin
            t  = int'($urandom_range(0, 4));
            op = int'($urandom_range(0, 15));
            a  = int'($urandom_range(0, 30));
            b  = int'($urandom_range(0, 31));
            c  = int'($urandom_range(0, 31));
            if (t == 4) begin
               sel = int'($urandom_range(0, 3));
               mop = int'($urandom_range(0, 3));
               if (mop[0] && sel == 0) sel = 1;     // keep program RAM intact
               op = sel * 4 + mop;
            end
            mem[0][addr] = enc_r(t, op, a, b, c);
            addr++;
         end
         for (int r = 0; r < 31; r++) begin
            mem[0][addr] = enc_r(4, 4'b0101, r, 0, 0);
            addr++;
         end
         mem[0][addr] = enc_r(($urandom_range(0, 1) == 0) ? 5 : 7, 0, 0, 0, 0);
         do_reset();
         wait_halt(3000);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
`default_nettype wire
